// File: rtl/range_frame_tx.sv
// range_frame_tx: transmit side of the go/finish sample-stream protocol.
// Buffers up to Depth samples in a FIFO; on send emits one framed burst where go marks the
// first sample and finish the last, followed by a one-cycle gap carrying the done pulse.
// Tracks the unsigned max/min of the emitted samples and presents max - min as exp_range.
//
// Ports:
//   clock_i      system clock, rising edge
//   reset_i      synchronous, active-high reset
//   wr_data_i    sample to buffer
//   wr_valid_i   wr_data_i valid
//   wr_ready_o   buffer accepts a sample this cycle
//   send_i       request transmission of the buffered frame
//   flush_i      discard buffer contents (idle only)
//   count_o      samples currently buffered
//   busy_o       frame in progress
//   reject_o     one-cycle pulse: send refused (fewer than two samples)
//   data_out_o   sample to receiver
//   go_o         frame start, qualifies first sample
//   finish_o     frame end, qualifies last sample
//   done_o       one-cycle pulse: frame complete, exp_range_o valid
//   exp_range_o  max - min of last completed frame
module range_frame_tx #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [Width-1:0]           wr_data_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic                       send_i,
  input  logic                       flush_i,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       busy_o,
  output logic                       reject_o,
  output logic [Width-1:0]           data_out_o,
  output logic                       go_o,
  output logic                       finish_o,
  output logic                       done_o,
  output logic [Width-1:0]           exp_range_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef enum logic [2:0] {StIdle, StFirst, StBody, StLast, StGap} state_e;

  state_e           state_q;
  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] data_q, max_q, min_q, exp_q;
  logic             go_q, finish_q, done_q, reject_q;

  logic             idle, push, pop, start, refuse;
  logic [Width-1:0] head;

  always_comb begin
    idle       = (state_q == StIdle);
    wr_ready_o = idle && (count_q < CntW'(Depth));
    start      = idle && send_i && !flush_i && (count_q >= CntW'(2));
    refuse     = idle && send_i && !flush_i && (count_q < CntW'(2));
    // flush beats a same-cycle write
    push       = wr_valid_i && wr_ready_o && !flush_i;
    // The sample for the state being entered is popped on the entry edge.
    pop        = start || (state_q == StFirst) || (state_q == StBody);
    head       = mem_q[rd_ptr_q];
    if (idle && flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // A write accepted on the same edge as send joins the frame, so the frame length is simply
  // whatever count_q holds while in flight and the buffer is always empty by the gap cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      go_q     <= 1'b0;
      finish_q <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      max_q    <= '0;
      min_q    <= '0;
      exp_q    <= '0;
    end else begin
      count_q  <= count_d;
      data_q   <= '0;
      go_q     <= 1'b0;
      finish_q <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= refuse;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        data_q   <= head;
      end
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
          end else if (start) begin
            state_q <= StFirst;
            go_q    <= 1'b1;
            max_q   <= head;
            min_q   <= head;
          end
        end
        StFirst, StBody: begin
          if (head > max_q) begin
            max_q <= head;
          end
          if (head < min_q) begin
            min_q <= head;
          end
          // count_q is the number of samples still to emit
          if (count_q == CntW'(1)) begin
            state_q  <= StLast;
            finish_q <= 1'b1;
          end else begin
            state_q <= StBody;
          end
        end
        StLast: begin
          state_q <= StGap;
          done_q  <= 1'b1;
          exp_q   <= max_q - min_q;
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign count_o     = count_q;
  assign busy_o      = !idle;
  assign reject_o    = reject_q;
  assign data_out_o  = data_q;
  assign go_o        = go_q;
  assign finish_o    = finish_q;
  assign done_o      = done_q;
  assign exp_range_o = exp_q;

endmodule

// File: tb/tb_range_frame_tx.sv
// Scoreboard bench for range_frame_tx: stimulus queues expected beats, ranges and rejects;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_range_frame_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       send;
  logic       flush;
  logic [3:0] count;
  logic       busy;
  logic       reject;
  logic [7:0] data_out;
  logic       go;
  logic       finish;
  logic       done;
  logic [7:0] exp_range;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       go;
    logic       fin;
  } beat_t;

  beat_t      exp_beats[$];
  logic [7:0] exp_ranges[$];
  logic [3:0] exp_rejects[$];

  range_frame_tx #(
    .Width(8),
    .Depth(8)
  ) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .wr_data_i  (wr_data),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .send_i     (send),
    .flush_i    (flush),
    .count_o    (count),
    .busy_o     (busy),
    .reject_o   (reject),
    .data_out_o (data_out),
    .go_o       (go),
    .finish_o   (finish),
    .done_o     (done),
    .exp_range_o(exp_range)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: DUT outputs change only at posedge, sampled here at negedge.
  always @(negedge clock) begin
    if (busy === 1'b1 && done === 1'b0) begin
      if (exp_beats.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0d go %0b finish %0b, expected none",
                 data_out, go, finish);
      end else begin
        beat_t b;
        b = exp_beats.pop_front();
        check("beat_data", 32'(data_out), 32'(b.data));
        check("beat_go", 32'(go), 32'(b.go));
        check("beat_finish", 32'(finish), 32'(b.fin));
      end
    end else if (busy === 1'b0) begin
      check("idle_go_finish", {30'd0, go, finish}, 32'd0);
    end
    if (done === 1'b1) begin
      if (exp_ranges.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got range %0d, expected no done", exp_range);
      end else begin
        logic [7:0] r;
        r = exp_ranges.pop_front();
        check("exp_range", 32'(exp_range), 32'(r));
      end
    end
    if (reject === 1'b1) begin
      if (exp_rejects.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_reject: got reject with count %0d, expected none", count);
      end else begin
        logic [3:0] c;
        c = exp_rejects.pop_front();
        check("reject_count", 32'(count), 32'(c));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_sample(input logic [7:0] v);
    wr_data  = v;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // Queue the expected frame, issue send, and wait for the frame to end.
  task automatic send_frame(input logic [7:0] s[$], input logic [7:0] rng);
    for (int i = 0; i < s.size(); i++) begin
      exp_beats.push_back({s[i], (i == 0), (i == s.size() - 1)});
    end
    exp_ranges.push_back(rng);
    send = 1'b1;
    tick();
    send = 1'b0;
    wait_idle("frame_ends");
  endtask

  initial begin
    logic [7:0] s[$];
    reset    = 1'b1;
    wr_data  = '0;
    wr_valid = 1'b0;
    send     = 1'b0;
    flush    = 1'b0;
    tick();
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {28'd0, reject, go, finish, done}, 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_exp_range", 32'(exp_range), 32'd0);
    reset = 1'b0;
    tick();

    // 5,9,2,7 -> range 7
    s = '{8'd5, 8'd9, 8'd2, 8'd7};
    foreach (s[i]) write_sample(s[i]);
    check("count_4", 32'(count), 32'd4);
    send_frame(s, 8'd7);
    check("count_after_f1", 32'(count), 32'd0);

    // 3,3 -> range 0, no body cycle
    s = '{8'd3, 8'd3};
    foreach (s[i]) write_sample(s[i]);
    send_frame(s, 8'd0);

    // Single sample: send rejected, buffer kept
    write_sample(8'd42);
    exp_rejects.push_back(4'd1);
    send = 1'b1;
    tick();
    send = 1'b0;
    tick();
    check("reject_keeps_count", 32'(count), 32'd1);
    check("reject_not_busy", 32'(busy), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_empties", 32'(count), 32'd0);

    // send with flush: flush wins, no frame, no reject
    write_sample(8'd4);
    write_sample(8'd6);
    send  = 1'b1;
    flush = 1'b1;
    tick();
    send  = 1'b0;
    flush = 1'b0;
    tick();
    check("send_flush_count", 32'(count), 32'd0);
    check("send_flush_busy", 32'(busy), 32'd0);

    // Fill to depth, 9th dropped
    s = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    foreach (s[i]) write_sample(s[i]);
    check("full_count", 32'(count), 32'd8);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    write_sample(8'd9);
    check("full_drop_count", 32'(count), 32'd8);
    send_frame(s, 8'd7);

    // send and writes during a frame are ignored
    s = '{8'd10, 8'd20, 8'd30};
    foreach (s[i]) write_sample(s[i]);
    foreach (s[i]) exp_beats.push_back({s[i], (i == 0), (i == 2)});
    exp_ranges.push_back(8'd20);
    send = 1'b1;
    tick();
    wr_data  = 8'd99;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_wr_ready", 32'(wr_ready), 32'd0);
      tick();
    end
    send     = 1'b0;
    wr_valid = 1'b0;
    wait_idle("mid_frame_ends");
    check("mid_count_end", 32'(count), 32'd0);

    // Reset during body of a 6-sample frame
    s = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66};
    foreach (s[i]) write_sample(s[i]);
    exp_beats.push_back({8'd11, 1'b1, 1'b0});
    exp_beats.push_back({8'd22, 1'b0, 1'b0});
    send = 1'b1;
    tick();
    send = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_go_finish", {30'd0, go, finish}, 32'd0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_exp_range", 32'(exp_range), 32'd0);
    s = '{8'd200, 8'd10};
    foreach (s[i]) write_sample(s[i]);
    send_frame(s, 8'd190);
    tick();
    tick();

    check("beats_drained", 32'(exp_beats.size()), 32'd0);
    check("ranges_drained", 32'(exp_ranges.size()), 32'd0);
    check("rejects_drained", 32'(exp_rejects.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
